// File: rtl/des_key_schedule_gen.sv
// des_key_schedule_gen: iterative DES key schedule, one 48-bit round key per clock.
// Optional build macro DES_KEY_PARITY_CHECK_EN adds a per-byte odd-parity check.
module des_key_schedule_gen #(
    parameter int NUM_ROUNDS = 16,
    parameter int KEY_W      = 48
) (
    input  logic                               clk,
    input  logic                               n_rst,
    input  logic                               start,
    input  logic [0:63]                        key_in,
    input  logic                               decrypt,
    output logic                               busy,
    output logic                               keys_valid,
    output logic [0:NUM_ROUNDS-1][0:KEY_W-1]   round_keys,
    output logic                               parity_error
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    localparam int PC1 [56] = '{
        56, 48, 40, 32, 24, 16,  8,  0, 57, 49, 41, 33, 25, 17,
         9,  1, 58, 50, 42, 34, 26, 18, 10,  2, 59, 51, 43, 35,
        62, 54, 46, 38, 30, 22, 14,  6, 61, 53, 45, 37, 29, 21,
        13,  5, 60, 52, 44, 36, 28, 20, 12,  4, 27, 19, 11,  3
    };

    localparam int PC2 [48] = '{
        13, 16, 10, 23,  0,  4,  2, 27, 14,  5, 20,  9,
        22, 18, 11,  3, 25,  7, 15,  6, 26, 19, 12,  1,
        40, 51, 30, 36, 46, 54, 29, 39, 50, 44, 32, 47,
        43, 48, 38, 55, 33, 52, 45, 41, 49, 35, 28, 31
    };

    state_e                             state_q, state_d;
    logic [0:27]                        c_q, c_d, d_q, d_d;
    logic [0:27]                        pc1_c, pc1_d, rot_c, rot_d;
    logic [0:55]                        cd_rot;
    logic [0:KEY_W-1]                   pc2_k;
    logic [3:0]                         cnt_q, cnt_d, slot;
    logic                               mode_q, mode_d;
    logic [0:NUM_ROUNDS-1][0:KEY_W-1]   keys_q, keys_d;
    logic                               one_shift, accept;

    for (genvar g = 0; g < 28; g++) begin : g_pc1
        assign pc1_c[g] = key_in[PC1[g]];
        assign pc1_d[g] = key_in[PC1[g+28]];
    end

    // Rounds 1, 2, 9 and 16 rotate by one; all others by two.
    always_comb begin
        one_shift = (cnt_q == 4'd0) || (cnt_q == 4'd1) ||
                    (cnt_q == 4'd8) || (cnt_q == 4'd15);
        rot_c = one_shift ? {c_q[1:27], c_q[0]} : {c_q[2:27], c_q[0:1]};
        rot_d = one_shift ? {d_q[1:27], d_q[0]} : {d_q[2:27], d_q[0:1]};
    end

    assign cd_rot = {rot_c, rot_d};

    for (genvar g = 0; g < 48; g++) begin : g_pc2
        assign pc2_k[g] = cd_rot[PC2[g]];
    end

    assign slot   = mode_q ? (4'd15 - cnt_q) : cnt_q;
    assign accept = start && (state_q != S_RUN);

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        keys_d  = keys_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_d = S_RUN;
                    c_d     = pc1_c;
                    d_d     = pc1_d;
                    cnt_d   = 4'd0;
                    mode_d  = decrypt;
                end
            end
            S_RUN: begin
                c_d          = rot_c;
                d_d          = rot_d;
                cnt_d        = cnt_q + 4'd1;
                keys_d[slot] = pc2_k;
                if (cnt_q == 4'd15) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            c_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            keys_q  <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            keys_q  <= keys_d;
        end
    end

    assign busy       = (state_q == S_RUN);
    assign keys_valid = (state_q == S_DONE);
    assign round_keys = keys_q;

`ifdef DES_KEY_PARITY_CHECK_EN
    logic [7:0] byte_even;
    logic       par_q;

    for (genvar b = 0; b < 8; b++) begin : g_par
        assign byte_even[b] = ~^key_in[8*b +: 8];
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            par_q <= 1'b0;
        end else if (accept) begin
            par_q <= |byte_even;
        end
    end

    assign parity_error = par_q;
`else
    // PC-1 discards the parity bits; they only matter to the optional check.
    logic unused_parity_bits;
    assign unused_parity_bits = ^{key_in[7],  key_in[15], key_in[23], key_in[31],
                                  key_in[39], key_in[47], key_in[55], key_in[63]};
    assign parity_error = 1'b0;
`endif

endmodule
